// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
//   tx_state_e : transmitter FSM states
//   parity_e   : parity modes decoded from the PARITY_BIT string
//   calc_div   : clock cycles per bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  function automatic int calc_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy level.
//   clk, rst_n    : clock, async active-low reset
//   push, wdata   : write (ignored while full)
//   pop, rdata    : read (ignored while empty); rdata shows the head word
//   full, empty   : occupancy flags
//   level         : words currently stored, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rptr_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a FIFO, frames
// serialised back-to-back (start, FRAME_WD data bits LSB first, optional
// parity, STOP_BITS stop bits), each bit DIV = CLK_FREQUENCE/BPS cycles.
//   clk, rst_n  : clock, async active-low reset
//   s_valid/s_data/s_ready : write stream, s_ready = !full
//   fifo_level  : words buffered
//   tx_busy     : a frame (or break) is on the line
//   tx_done     : pulse in the last cycle of each frame's final stop bit
//   uart_tx     : registered serial line, idle high
// Optional: define UART_TX_BREAK_EN to add input break_req, which holds the
// line low between frames and guarantees one idle bit time after release.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BPS           = 115_200,
  parameter string PARITY_BIT    = "NONE",
  parameter int    FRAME_WD      = 8,
  parameter int    STOP_BITS     = 1,
  parameter int    FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [FRAME_WD-1:0]           s_data,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          tx_done,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          uart_tx
);

  localparam int      DIV   = calc_div(CLK_FREQUENCE, BPS);
  localparam int      BW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam parity_e PMODE = (PARITY_BIT == "EVEN") ? PAR_EVEN :
                              (PARITY_BIT == "ODD")  ? PAR_ODD  : PAR_NONE;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(FRAME_WD - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_FREQUENCE/BPS must be at least 2");
  end
  if (FRAME_WD < 5 || FRAME_WD > 9) begin : g_bad_wd
    $error("uart_tx_fifo: FRAME_WD must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY_BIT != "NONE" && PARITY_BIT != "EVEN" && PARITY_BIT != "ODD") begin : g_bad_par
    $error("uart_tx_fifo: PARITY_BIT must be NONE, EVEN or ODD");
  end

  tx_state_e           state_q, state_d;
  logic [BW-1:0]       baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [FRAME_WD-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                brk_q, brk_d;
  logic                pop, baud_end, hold, fifo_empty, fifo_full;
  logic [FRAME_WD-1:0] fifo_rdata;

  uart_sync_fifo #(.WIDTH(FRAME_WD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready = !fifo_full;
  assign uart_tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    brk_d    = brk_q;
    pop      = 1'b0;
    done_d   = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
    // Line and flags are derived from the current state and registered, so
    // they trail the state by one cycle; all three stay mutually aligned.
    busy_d   = (state_q != IDLE);
    tx_d     = 1'b1;
`ifdef UART_TX_BREAK_EN
    // brk_q marks the post-break recovery bit: no pop until it elapses.
    hold     = break_req || brk_q;
`else
    hold     = 1'b0;
`endif

    if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + BW'(1);

    case (state_q)
      IDLE: begin
        baud_d = '0;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          tx_d   = 1'b0;
          busy_d = 1'b1;
          brk_d  = 1'b1;
        end else if (brk_q) begin
          baud_d = baud_end ? '0 : baud_q + BW'(1);
          if (baud_end) brk_d = 1'b0;
        end
`endif
        if (!hold && !fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PMODE == PAR_NONE) ? STOP : PARITY;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        tx_d = par_q;
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            bit_d  = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!hold && !fifo_empty) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_rdata;
      par_d   = (PMODE == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
